// File: rtl/adg_mux_scanner_pkg.sv
// Shared types, mode encodings and phase-length helper for the ADG7xx mux channel sequencer.
package adg_mux_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DWELL = 3'd4
    } state_t;

    localparam logic [1:0] MODE_SCAN   = 2'd0;
    localparam logic [1:0] MODE_STEP   = 2'd1;
    localparam logic [1:0] MODE_MANUAL = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    // Number of cycles a phase occupies; IDLE has no timed length.
    function automatic int unsigned phase_len(input state_t s,
                                              input int unsigned setup_c,
                                              input int unsigned wr_c,
                                              input int unsigned hold_c,
                                              input int unsigned dwell_c);
        int unsigned len;
        len = 1;
        case (s)
            ST_SETUP: len = setup_c;
            ST_WRITE: len = wr_c;
            ST_HOLD:  len = hold_c;
            ST_DWELL: len = dwell_c;
            default:  len = 1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/adg_mux_scanner_phase_timer.sv
// Loadable down-counter timing the SETUP/WRITE/HOLD/DWELL phases; done is registered.
module phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // done mirrors (cnt == 0) but is produced from the next count value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            done <= (load_val == '0);
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/adg_mux_scanner.sv
// Channel sequencer for ADG7xx analog muxes: ordered CS/WR/EN writes, scan/step/manual modes.
module adg_mux_scanner
    import adg_mux_scanner_pkg::*;
#(
    parameter int unsigned NUM_CH            = 32,
    parameter int unsigned ADDR_W            = 5,
    parameter int unsigned DWELL_CYCLES      = 10_000_000,
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned WR_PULSE_CYCLES   = 2,
    parameter int unsigned HOLD_CYCLES       = 2,
    parameter int unsigned BREAK_BEFORE_MAKE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              run,
    input  logic              step,
    input  logic [ADDR_W-1:0] manual_ch,
    output logic              en_n,
    output logic              cs_n,
    output logic              wr_n,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] cur_ch,
    output logic              settled,
    output logic              ch_strobe,
    output logic              scan_done,
    output logic              sel_err
);

    localparam int unsigned MAX_SWH = (SETUP_CYCLES > WR_PULSE_CYCLES)
                                    ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                                    : ((WR_PULSE_CYCLES > HOLD_CYCLES) ? WR_PULSE_CYCLES : HOLD_CYCLES);
    localparam int unsigned MAX_LEN = (DWELL_CYCLES > MAX_SWH) ? DWELL_CYCLES : MAX_SWH;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] target, target_nxt;
    logic [1:0]        mode_q, mode_q_nxt;
    logic              written, written_nxt;
    logic              en_n_nxt, cs_n_nxt, wr_n_nxt;
    logic [ADDR_W-1:0] addr_nxt, cur_ch_nxt;
    logic              settled_nxt, ch_strobe_nxt, scan_done_nxt, sel_err_nxt;
    logic              timer_load, timer_done;
    logic [CNT_W-1:0]  timer_val;
    logic              manual_ok;

    function automatic logic [ADDR_W-1:0] next_ch(input logic [ADDR_W-1:0] c);
        return (32'(c) == NUM_CH - 1) ? '0 : c + ADDR_W'(1);
    endfunction

    assign manual_ok = (32'(manual_ch) < NUM_CH);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            target    <= '0;
            mode_q    <= MODE_SCAN;
            written   <= 1'b0;
            en_n      <= 1'b1;
            cs_n      <= 1'b1;
            wr_n      <= 1'b1;
            addr      <= '0;
            cur_ch    <= '0;
            settled   <= 1'b0;
            ch_strobe <= 1'b0;
            scan_done <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            mode_q    <= mode_q_nxt;
            written   <= written_nxt;
            en_n      <= en_n_nxt;
            cs_n      <= cs_n_nxt;
            wr_n      <= wr_n_nxt;
            addr      <= addr_nxt;
            cur_ch    <= cur_ch_nxt;
            settled   <= settled_nxt;
            ch_strobe <= ch_strobe_nxt;
            scan_done <= scan_done_nxt;
            sel_err   <= sel_err_nxt;
        end
    end

    // Next state, then output values derived from the state being entered.
    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        mode_q_nxt  = mode_q;
        sel_err_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (mode == MODE_SCAN && run) begin
                    state_nxt  = ST_SETUP;
                    target_nxt = cur_ch;
                end else if (mode == MODE_STEP && run && step) begin
                    state_nxt  = ST_SETUP;
                    target_nxt = next_ch(cur_ch);
                end else if (mode == MODE_MANUAL && step) begin
                    if (manual_ok) begin
                        state_nxt  = ST_SETUP;
                        target_nxt = manual_ch;
                    end else begin
                        sel_err_nxt = 1'b1;
                    end
                end
            end
            ST_SETUP: if (timer_done) state_nxt = ST_WRITE;
            ST_WRITE: if (timer_done) state_nxt = ST_HOLD;
            ST_HOLD:  if (timer_done) state_nxt = ST_DWELL;
            ST_DWELL: begin
                case (mode)
                    MODE_SCAN: begin
                        if (timer_done) begin
                            if (run) begin
                                state_nxt  = ST_SETUP;
                                target_nxt = next_ch(cur_ch);
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end
                    end
                    MODE_STEP: begin
                        if (!run) begin
                            state_nxt = ST_IDLE;
                        end else if (step) begin
                            state_nxt  = ST_SETUP;
                            target_nxt = next_ch(cur_ch);
                        end
                    end
                    MODE_MANUAL: begin
                        if (step) begin
                            if (manual_ok) begin
                                state_nxt  = ST_SETUP;
                                target_nxt = manual_ch;
                            end else begin
                                sel_err_nxt = 1'b1;
                            end
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (state_nxt == ST_SETUP && state != ST_SETUP) begin
            mode_q_nxt = mode;
        end

        timer_load = (state_nxt != state);
        timer_val  = CNT_W'(phase_len(state_nxt, SETUP_CYCLES, WR_PULSE_CYCLES,
                                      HOLD_CYCLES, DWELL_CYCLES) - 1);

        addr_nxt    = (state_nxt == ST_SETUP && state != ST_SETUP) ? target_nxt : addr;
        cur_ch_nxt  = (state_nxt == ST_HOLD && state == ST_WRITE) ? target : cur_ch;
        written_nxt = written | (state_nxt == ST_HOLD);
        cs_n_nxt    = !(state_nxt inside {ST_SETUP, ST_WRITE, ST_HOLD});
        wr_n_nxt    = (state_nxt != ST_WRITE);
        settled_nxt = (state_nxt == ST_DWELL);

        // Without break-before-make the mux stays enabled across later channel changes.
        en_n_nxt = 1'b1;
        if (state_nxt == ST_DWELL) begin
            en_n_nxt = 1'b0;
        end else if (state_nxt != ST_IDLE && BREAK_BEFORE_MAKE == 0 && written_nxt) begin
            en_n_nxt = 1'b0;
        end

        ch_strobe_nxt = (state_nxt == ST_DWELL && state == ST_HOLD);
        scan_done_nxt = ch_strobe_nxt && (mode_q == MODE_SCAN) && (32'(target) == NUM_CH - 1);
    end

endmodule

// File: tb/tb_adg_mux_scanner.sv
// Self-checking bench for adg_mux_scanner: timeline table, write-window monitor, scan/step/manual/reset sequences.
module tb_adg_mux_scanner;

    localparam int NUM_CH = 20;
    localparam int ADDR_W = 6;
    localparam int DWELL  = 8;
    localparam int S      = 2;
    localparam int W      = 2;
    localparam int H      = 2;
    localparam int WIN    = S + W + H;
    localparam int PERIOD = WIN + DWELL;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic              run;
    logic              step;
    logic [ADDR_W-1:0] manual_ch;
    logic              en_n, cs_n, wr_n, settled, ch_strobe, scan_done, sel_err;
    logic [ADDR_W-1:0] addr, cur_ch;

    adg_mux_scanner #(
        .NUM_CH            (NUM_CH),
        .ADDR_W            (ADDR_W),
        .DWELL_CYCLES      (DWELL),
        .SETUP_CYCLES      (S),
        .WR_PULSE_CYCLES   (W),
        .HOLD_CYCLES       (H),
        .BREAK_BEFORE_MAKE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .run       (run),
        .step      (step),
        .manual_ch (manual_ch),
        .en_n      (en_n),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .addr      (addr),
        .cur_ch    (cur_ch),
        .settled   (settled),
        .ch_strobe (ch_strobe),
        .scan_done (scan_done),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [5:0]  addr;
        logic        cs_n;
        logic        wr_n;
        logic        en_n;
        logic        settled;
        logic        ch_strobe;
        logic        scan_done;
        logic [5:0]  cur_ch;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Expected channel of each completed write, in order.
    int exp_q[$];

    // Write-window monitor state.
    bit                in_win = 1'b0;
    int                cs_len, wr_len;
    logic [ADDR_W-1:0] win_addr;
    bit                addr_ok, en_ok;
    logic              prev_wr = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] pack(input logic [5:0] a, input logic cs, input logic wr,
                                         input logic en, input logic st, input logic sb,
                                         input logic sd, input logic [5:0] cc);
        return {14'd0, a, cs, wr, en, st, sb, sd, cc};
    endfunction

    function automatic logic [31:0] dut_vec();
        return pack(addr, cs_n, wr_n, en_n, settled, ch_strobe, scan_done, cur_ch);
    endfunction

    // Advance one clock, sample just after the edge, and audit any chip-select window.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            in_win  = 1'b0;
            prev_wr = 1'b1;
        end else begin
            if (!cs_n) begin
                if (!in_win) begin
                    in_win   = 1'b1;
                    cs_len   = 0;
                    wr_len   = 0;
                    win_addr = addr;
                    addr_ok  = 1'b1;
                    en_ok    = 1'b1;
                end
                cs_len++;
                if (!wr_n) wr_len++;
                if (addr !== win_addr) addr_ok = 1'b0;
                if (en_n !== 1'b1) en_ok = 1'b0;
                if (prev_wr === 1'b0 && wr_n === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_write: got addr %0d, expected no write (cycle %0d)", addr, cyc);
                    end else begin
                        check("write_addr", 32'(addr), 32'(exp_q.pop_front()));
                    end
                end
            end else if (in_win) begin
                in_win = 1'b0;
                check("wr_low_len", 32'(wr_len), 32'(W));
                check("cs_low_len", 32'(cs_len), 32'(WIN));
                check("addr_stable", 32'(addr_ok), 32'd1);
                check("bbm_en_high", 32'(en_ok), 32'd1);
            end
            prev_wr = wr_n;
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic wait_strobe(input int bound, output int k);
        k = 0;
        while (!ch_strobe && k < bound) begin
            tick();
            k++;
        end
        check("strobe_arrives", 32'(ch_strobe), 32'd1);
    endtask

    task automatic wait_write(input int bound);
        int k;
        k = 0;
        while (wr_n && k < bound) begin
            tick();
            k++;
        end
        check("write_arrives", 32'(wr_n), 32'd0);
    endtask

    initial begin
        vec_t tbl[13];
        int   base, strobes, last_strobe, k, exp_ch, model_cur;
        int   man_list[$];

        rst = 1'b1; mode = 2'd0; run = 1'b0; step = 1'b0; manual_ch = '0;

        tbl[0]  = '{0,  6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1,  6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[2]  = '{2,  6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[3]  = '{3,  6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[4]  = '{4,  6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[5]  = '{5,  6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[6]  = '{7,  6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        tbl[7]  = '{8,  6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[8]  = '{14, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[9]  = '{15, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[10] = '{17, 6'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[11] = '{19, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[12] = '{21, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1};

        repeat (3) tick();
        rst  = 1'b0;

        // SCAN timeline from the start condition (edge 0).
        for (int i = 0; i < 22; i++) exp_q.push_back(i % NUM_CH);
        mode = 2'd0;
        run  = 1'b1;
        base = cyc;
        for (int i = 0; i < 13; i++) begin
            while (cyc - base < tbl[i].cyc) tick();
            check($sformatf("scan_vec[c%0d]", tbl[i].cyc), dut_vec(),
                  pack(tbl[i].addr, tbl[i].cs_n, tbl[i].wr_n, tbl[i].en_n, tbl[i].settled,
                       tbl[i].ch_strobe, tbl[i].scan_done, tbl[i].cur_ch));
        end

        // Continue scanning through the wrap; strobes must be one channel period apart.
        strobes     = 2;
        last_strobe = cyc;
        k = 0;
        while (strobes < 22 && k < 22 * PERIOD + 20) begin
            tick();
            k++;
            if (ch_strobe) begin
                exp_ch = strobes % NUM_CH;
                check("strobe_period", 32'(cyc - last_strobe), 32'(PERIOD));
                check("strobe_ch", 32'(cur_ch), 32'(exp_ch));
                check("scan_done_at_strobe", 32'(scan_done), 32'(exp_ch == NUM_CH - 1));
                strobes++;
                last_strobe = cyc;
            end else if (scan_done) begin
                check("scan_done_without_strobe", 32'(ch_strobe), 32'd1);
            end
        end
        check("scan_strobe_count", 32'(strobes), 32'd22);
        check("scan_writes_consumed", 32'(exp_q.size()), 32'd0);

        // Drop run two cycles into the dwell of channel 1: dwell completes, then IDLE.
        tick();
        tick();
        run = 1'b0;
        k = 0;
        while (settled && k < 20) begin
            tick();
            k++;
        end
        check("dwell_completes", 32'(k), 32'(DWELL - 2));
        check("idle_after_run_drop", dut_vec(), pack(6'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1));
        repeat (20) tick();
        check("idle_stays", 32'(cs_n), 32'd1);

        // STEP: three advances with a step during WRITE that must be dropped.
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        mode = 2'd1;
        run  = 1'b1;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        pulse_step();
        wait_strobe(20, k);
        check("step1_latency", 32'(k), 32'(WIN));
        check("step1_ch", 32'(cur_ch), 32'd1);
        repeat (40) tick();
        check("step_settled_held", 32'({settled, en_n, cur_ch}), {24'd0, 1'b1, 1'b0, 6'd1});
        pulse_step();
        wait_write(10);
        pulse_step();
        wait_strobe(20, k);
        check("step2_ch", 32'(cur_ch), 32'd2);
        repeat (15) tick();
        check("midwrite_step_ignored", 32'({settled, cur_ch}), {25'd0, 1'b1, 6'd2});
        pulse_step();
        wait_strobe(20, k);
        check("step3_ch", 32'(cur_ch), 32'd3);
        check("step_writes_consumed", 32'(exp_q.size()), 32'd0);

        // Reset asserted during WRITE abandons the write.
        pulse_step();
        wait_write(10);
        rst = 1'b1;
        tick();
        check("reset_mid_write", dut_vec(), pack(6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
        check("reset_sel_err", 32'(sel_err), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("idle_after_reset", 32'({cs_n, wr_n, en_n}), 32'd7);

        // MANUAL: fixed boundary cases then random targets, against a running model of cur_ch.
        mode = 2'd2;
        run  = 1'b0;
        model_cur = 0;
        man_list = '{17, 40, 19, 20, 0, 63};
        for (int i = 0; i < 16; i++) man_list.push_back(int'($urandom_range(0, 39)));
        foreach (man_list[i]) begin
            manual_ch = ADDR_W'(man_list[i]);
            pulse_step();
            if (man_list[i] < NUM_CH) begin
                exp_q.push_back(man_list[i]);
                check("manual_setup", 32'({cs_n, addr, sel_err}), 32'({1'b0, 6'(man_list[i]), 1'b0}));
                wait_strobe(20, k);
                check("manual_latency", 32'(k), 32'(WIN));
                check("manual_cur_ch", 32'(cur_ch), 32'(man_list[i]));
                model_cur = man_list[i];
            end else begin
                check("sel_err_pulse", 32'(sel_err), 32'd1);
                check("sel_err_cur_kept", 32'(cur_ch), 32'(model_cur));
                tick();
                check("sel_err_single", 32'({sel_err, cs_n}), 32'd1);
            end
        end
        check("manual_writes_consumed", 32'(exp_q.size()), 32'd0);

        // Reserved mode leaves DWELL for IDLE.
        mode = 2'd3;
        tick();
        check("mode3_idle", 32'({en_n, settled, cs_n}), 32'b101);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
